// File: rtl/multi_sel_pkg.sv
// Shared constants and phase encoding for the multi_sel stream (tx and rx).
package multi_sel_pkg;

  localparam int unsigned D_W   = 8;
  localparam int unsigned OUT_W = D_W + 3;

  // Per-phase multipliers applied to the operand by the transmitter
  localparam int unsigned MUL_PH1 = 3;
  localparam int unsigned MUL_PH2 = 7;
  localparam int unsigned MUL_PH3 = 8;

  typedef enum logic [2:0] {
    HUNT = 3'd0,
    PH1  = 3'd1,
    PH2  = 3'd2,
    PH3  = 3'd3,
    EXP0 = 3'd4
  } phase_e;

endpackage

// File: rtl/multi_sel_rx_if.sv
// Stream-in / operand-out bundle of the multi_sel receiver.
interface multi_sel_rx_if #(
  parameter int unsigned D_W   = 8,
  parameter int unsigned OUT_W = 11,
  parameter int unsigned CNT_W = 8
);

  logic             in_grant;
  logic [OUT_W-1:0] in_data;
  logic             m_valid;
  logic             m_ready;
  logic [D_W-1:0]   m_data;
  logic             err;
  logic             drop;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] drop_cnt;

  // Stream source / downstream sink side
  modport master (
    output in_grant, in_data, m_ready,
    input  m_valid, m_data, err, drop, err_cnt, drop_cnt
  );

  // Receiver side
  modport slave (
    input  in_grant, in_data, m_ready,
    output m_valid, m_data, err, drop, err_cnt, drop_cnt
  );

endinterface

// File: rtl/sync_fifo2.sv
// Two-entry FIFO with registered head, full and empty; push+pop allowed together.
module sync_fifo2 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic [1:0]   count;
  logic [1:0]   count_nxt;
  logic         do_pop;
  logic         do_push;

  // A pop while full frees a slot, so the push is accepted
  assign do_pop    = pop && (count != 2'd0);
  assign do_push   = push && ((count != 2'd2) || do_pop);
  assign count_nxt = count + 2'(do_push) - 2'(do_pop);

  // Storage: head is always the oldest entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_pop) begin
        if (count == 2'd2) begin
          head <= tail;
          if (do_push) tail <= din;
        end else if (do_push) begin
          head <= din;
        end
      end else if (do_push) begin
        if (count == 2'd0) head <= din;
        else               tail <= din;
      end
      count <= count_nxt;
      full  <= (count_nxt == 2'd2);
      empty <= (count_nxt == 2'd0);
    end
  end

  assign dout = head;

endmodule

// File: rtl/multi_sel_rx.sv
// Frame-locking decoder for the multi_sel d/3d/7d/8d stream with FIFO'd output.
module multi_sel_rx #(
  parameter int unsigned D_W   = multi_sel_pkg::D_W,
  parameter int unsigned OUT_W = multi_sel_pkg::OUT_W,
  parameter int unsigned CNT_W = 8
) (
  input logic            clk,
  input logic            rst,
  multi_sel_rx_if.slave  bus
);

  import multi_sel_pkg::*;

  phase_e           state;
  phase_e           state_nxt;
  logic [D_W-1:0]   d_reg;
  logic [D_W-1:0]   d_nxt;
  logic             bad;
  logic             bad_nxt;
  logic             err_c;
  logic             drop_c;
  logic             push_c;
  logic             pop_c;
  logic             fifo_full;
  logic             fifo_empty;
  logic [D_W-1:0]   fifo_dout;
  logic [OUT_W-1:0] d_ext;
  logic [OUT_W-1:0] exp_val;
  logic             hi_bad;
  logic             mismatch;
  logic             err;
  logic             drop;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] drop_cnt;

  assign d_ext  = OUT_W'(d_reg);
  assign hi_bad = (bus.in_data[OUT_W-1:D_W] != '0);
  assign pop_c  = !fifo_empty && bus.m_ready;

  // Expected stream word for the current derived phase
  always_comb begin
    exp_val = '0;
    case (state)
      PH1:     exp_val = d_ext * OUT_W'(MUL_PH1);
      PH2:     exp_val = d_ext * OUT_W'(MUL_PH2);
      PH3:     exp_val = d_ext * OUT_W'(MUL_PH3);
      default: exp_val = '0;
    endcase
  end

  assign mismatch = (bus.in_data != exp_val);

  // Phase tracking, frame verdict and output decisions
  always_comb begin
    state_nxt = state;
    d_nxt     = d_reg;
    bad_nxt   = bad;
    err_c     = 1'b0;
    drop_c    = 1'b0;
    push_c    = 1'b0;
    if (bus.in_grant) begin
      // Grant always starts a new frame; mid-frame it aborts the old one
      state_nxt = PH1;
      d_nxt     = bus.in_data[D_W-1:0];
      bad_nxt   = hi_bad;
      err_c     = (state == PH1) || (state == PH2) || (state == PH3);
    end else begin
      case (state)
        HUNT: state_nxt = HUNT;
        PH1: begin
          bad_nxt   = bad | mismatch;
          state_nxt = PH2;
        end
        PH2: begin
          bad_nxt   = bad | mismatch;
          state_nxt = PH3;
        end
        PH3: begin
          state_nxt = EXP0;
          if (bad || mismatch)             err_c  = 1'b1;
          else if (fifo_full && !pop_c)    drop_c = 1'b1;
          else                             push_c = 1'b1;
        end
        EXP0: begin
          err_c     = 1'b1;
          state_nxt = HUNT;
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // Phase state, captured operand and error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= HUNT;
      d_reg    <= '0;
      bad      <= 1'b0;
      err      <= 1'b0;
      drop     <= 1'b0;
      err_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      state <= state_nxt;
      d_reg <= d_nxt;
      bad   <= bad_nxt;
      err   <= err_c;
      drop  <= drop_c;
      if (err_c && (err_cnt != '1))   err_cnt  <= err_cnt + CNT_W'(1);
      if (drop_c && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  sync_fifo2 #(.W(D_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .pop   (pop_c),
    .din   (d_reg),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.m_valid  = !fifo_empty;
  assign bus.m_data   = fifo_dout;
  assign bus.err      = err;
  assign bus.drop     = drop;
  assign bus.err_cnt  = err_cnt;
  assign bus.drop_cnt = drop_cnt;

endmodule

// File: doc/multi_sel_rx.md
# multi_sel_rx

Receive-side decoder for the `multi_sel` result stream: it locks onto the transmitter's `input_grant` framing and captures the four-phase sequence d, 3d, 7d, 8d. It checks the three derived phases against the first and hands each verified operand to downstream logic through a valid/ready interface backed by a 2-entry FIFO. It sits directly on the `out`/`input_grant` pair of `multi_sel` and counts framing and arithmetic errors.

## Interface
- `D_W`, default 8: operand width.
- `OUT_W`, default 11: input stream width; always D_W+3.
- `CNT_W`, default 8: width of the error and drop counters.
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_grant`  in  1  frame-start marker; high in the cycle `in_data` carries phase 0.
- `in_data`  in  OUT_W  result stream.
- `m_valid`  out  1  FIFO head valid; reset 0.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  D_W  recovered operand at FIFO head; reset 0.
- `err`  out  1  one-cycle pulse per rejected or aborted frame; reset 0.
- `drop`  out  1  one-cycle pulse when a good frame is lost because the FIFO is full; reset 0.
- `err_cnt`  out  CNT_W  saturating error count; reset 0.
- `drop_cnt`  out  CNT_W  saturating drop count; reset 0.

## Operation
- The state machine has five states: HUNT, PH1, PH2, PH3, EXP0. Reset enters HUNT.
- **HUNT:** non-grant cycles are ignored. `in_grant`=1 does the following and moves to PH1:
  - latches `d_reg` = `in_data[D_W-1:0]`;
  - sets `bad` = (`in_data[OUT_W-1:D_W]` != 0).
- **PH1:** expects `in_data` == 3·d_reg. Moves to PH2.
- **PH2:** expects `in_data` == 7·d_reg. Moves to PH3.
- **PH3:** expects `in_data` == {d_reg,3'b000}. Frame is complete; moves to EXP0.
- **EXP0:** `in_grant`=1 is handled exactly as in HUNT, with no error, and moves to PH1. `in_grant`=0 is a sync loss: pulse `err` and go to HUNT.
- Any mismatch in PH1–PH3 sets `bad`. The frame still runs to PH3 so that framing stays aligned.
- **Grant in PH1–PH3:** the current frame is aborted and `err` pulses. The grant cycle is then treated as a new phase 0, and the state moves to PH1.
- **End of frame (PH3 sample):**
  - `bad`=1: pulse `err` and do not push.
  - `bad`=0 and FIFO not full: push `d_reg`.
  - `bad`=0 and FIFO full: pulse `drop` and do not push.
- **Arithmetic:** all compares are done at OUT_W bits and zero-extended. 7·(2^D_W−1) fits in OUT_W. There is no truncation.
- **FIFO:** 2 entries. A pop happens when `m_valid` && `m_ready`.
  - Push and pop in the same cycle while full is legal: the pop frees a slot, so there is no drop.
  - Push and pop in the same cycle while holding one entry: count stays 1 and the head advances.
- **Counters:** increment on every `err` or `drop` pulse and saturate at all-ones.
- **Reset mid-frame:** the partial frame is discarded, the FIFO is emptied, all outputs return to their reset values, and the state returns to HUNT.

## Timing
- Call the sampling edges of phases 0..3 E0..E3.
- `d_reg` updates at E0.
- The push, `err`, or `drop` decision is registered at E3.
- `m_valid` rises, or `err`/`drop` pulses, in the cycle after E3. Latency is 4 edges from the phase-0 sample to output.
- An abort `err` is registered at the grant edge and is visible in the following cycle.
- In steady state there is one frame every 4 cycles, so the FIFO cannot overflow if `m_ready` is high at least 1 cycle in 4.
- `m_data` is stable while `m_valid`=1 and `m_ready`=0.
- `err` and `drop` never assert in the same cycle for the same frame.

## Structure
- Package `multi_sel_pkg`:
  - `D_W`/`OUT_W` localparams;
  - phase-state enum (HUNT, PH1, PH2, PH3, EXP0);
  - multiplier constants 3, 7, 8, shared with the transmitter.
- Sub-module `sync_fifo2`: parameterised width, 2 entries, push/pop/full/empty, same-cycle push+pop.
- The top level holds the FSM, the compare datapath and the counters.

## Test plan
- **Single frame:** stimulus grant with 8'hA5 (165), then 495, 1155, 1320, with `m_ready`=1. Response: `m_valid` for 1 cycle with `m_data`=8'hA5, `err`=0.
- **Corrupt phase:** stimulus d=10, then 30, 71, 80. Response: `err` pulse the cycle after E3, no push, `err_cnt`=1.
- **Early grant:** stimulus grant at PH2 with a new d=3 frame. Response: `err` pulse, `err_cnt`=1, and d=3 delivered 4 cycles later.
- **Backpressure:** stimulus `m_ready`=0 over 3 valid frames (d=1,2,3). Response: FIFO holds 1 and 2, `drop` pulses on frame 3, `drop_cnt`=1. On release the order is 1 then 2.
- **Sync loss and reset:** stimulus grant missing in EXP0. Response: `err` and state HUNT. Then assert `rst` mid-PH2; response: `m_valid`=0, both counters 0, no `err` after release.
